// File: rtl/axis_switch_pkg.sv
// axis_switch_pkg: shared types and round-robin helper for the switch output path
package axis_switch_pkg;
    localparam int N_PORTS_DEF = 4;
    typedef logic [$clog2(N_PORTS_DEF)-1:0] port_idx_t;
    typedef enum logic {IDLE, BUSY} state_t;
    function automatic int next_rr(int idx, int n);
        return (idx + 1) % n;
    endfunction
endpackage

// File: rtl/axis_rr_arbiter_rr_pick.sv
// rr_pick: first requester after last_grant, searched upward with wrap
module rr_pick
    import axis_switch_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] gnt_idx,
    output logic          any_req
);
    assign any_req = |req;
    always_comb begin
        int k;
        logic found;
        gnt_idx = last_grant;
        found = 1'b0;
        k = next_rr(int'(last_grant), N);
        for (int i = 0; i < N; i++) begin
            if (!found && req[k]) begin
                gnt_idx = IW'(k);
                found = 1'b1;
            end
            k = next_rr(k, N);
        end
    end
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: N-to-1 AXI-Stream packet arbiter, round-robin, grant locked per packet
module axis_rr_arbiter
    import axis_switch_pkg::*;
#(
    parameter int N_PORTS      = 4,
    parameter int T_DATA_WIDTH = 8,
    parameter int T_ID_WIDTH   = 8,
    parameter int T_USER_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [N_PORTS*T_DATA_WIDTH-1:0]  s_data,
    input  logic [N_PORTS*T_ID_WIDTH-1:0]    s_id,
    input  logic [N_PORTS*T_USER_WIDTH-1:0]  s_user,
    input  logic [N_PORTS-1:0]               s_last,
    input  logic [N_PORTS-1:0]               s_valid,
    output logic [N_PORTS-1:0]               s_ready,
    output logic [T_DATA_WIDTH-1:0]          m_data,
    output logic [T_ID_WIDTH-1:0]            m_id,
    output logic [T_USER_WIDTH-1:0]          m_user,
    output logic [$clog2(N_PORTS)-1:0]       m_src,
    output logic                             m_last,
    output logic                             m_valid,
    input  logic                             m_ready
);
    localparam int IW = $clog2(N_PORTS);

    state_t        state;
    logic [IW-1:0] grant, last_grant, pick;
    logic          any_req, hs;

    rr_pick #(.N(N_PORTS), .IW(IW)) u_pick (
        .req        (s_valid),
        .last_grant (last_grant),
        .gnt_idx    (pick),
        .any_req    (any_req)
    );

    // Slot accepts a beat when empty or draining in the same cycle
    assign s_ready = (state == BUSY && (!m_valid || m_ready)) ? N_PORTS'(1) << grant : '0;
    assign hs      = s_valid[grant] & s_ready[grant];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(N_PORTS - 1);
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_data     <= '0;
            m_id       <= '0;
            m_user     <= '0;
            m_src      <= '0;
        end else begin
            if (hs) begin
                m_data  <= s_data[int'(grant)*T_DATA_WIDTH +: T_DATA_WIDTH];
                m_id    <= s_id[int'(grant)*T_ID_WIDTH +: T_ID_WIDTH];
                m_user  <= s_user[int'(grant)*T_USER_WIDTH +: T_USER_WIDTH];
                m_last  <= s_last[grant];
                m_src   <= grant;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            case (state)
                IDLE: if (any_req) begin
                    grant <= pick;
                    state <= BUSY;
                end
                BUSY: if (hs && s_last[grant]) begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: randomized packet sources checked against a packet-level arbitration model
module tb_axis_rr_arbiter;
    import axis_switch_pkg::*;
    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N*DW-1:0] s_data, s_id, s_user;
    logic [N-1:0]    s_last, s_valid, s_ready;
    logic [DW-1:0]   m_data, m_id, m_user;
    logic [1:0]      m_src;
    logic            m_last, m_valid;
    logic            m_ready = 1'b0;

    axis_rr_arbiter #(.N_PORTS(N), .T_DATA_WIDTH(DW), .T_ID_WIDTH(DW), .T_USER_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_data(s_data), .s_id(s_id), .s_user(s_user), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_id(m_id), .m_user(m_user), .m_src(m_src),
        .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] cur_data[N], cur_id[N], cur_user[N];
    logic [N-1:0]  cur_last = '0, v = '0, go = '0, gap = '0;
    int            rem[N], bno[N];
    int            plen = 0, pv = 100, pr = 100;
    logic          fixd = 1'b0;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            s_data[k*DW +: DW] = cur_data[k];
            s_id[k*DW +: DW]   = cur_id[k];
            s_user[k*DW +: DW] = cur_user[k];
        end
        s_last  = cur_last;
        s_valid = v;
    end

    int          idle, g, lastg;
    logic        mv;
    logic [26:0] slot;
    logic        out_in;
    int          starts[$];
    logic [7:0]  outs[$];
    int          n_vec = 0, n_bad = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr(logic [N-1:0] req, int last);
        for (int i = 1; i <= N; i++)
            if (req[(last + i) % N]) return (last + i) % N;
        return last;
    endfunction

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            rem[k] = 0; bno[k] = 0;
            cur_data[k] = '0; cur_id[k] = '0; cur_user[k] = '0;
        end
        v = '0; cur_last = '0; go = '0; gap = '0;
        idle = 1; g = 0; lastg = N - 1; mv = 1'b0; slot = '0; out_in = 1'b0;
        starts.delete(); outs.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_all();
        #1;
        chk("rst_mv", m_valid, 0);
        chk("rst_out", {m_data, m_id, m_user, m_last, m_src}, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic advance(logic [N-1:0] hs);
        for (int k = 0; k < N; k++) begin
            if (hs[k]) rem[k]--;
            if (!v[k] || hs[k]) begin
                if ((rem[k] > 0 || go[k]) && !gap[k] && $urandom_range(99) < pv) begin
                    if (rem[k] == 0) begin
                        rem[k] = (plen != 0) ? plen : $urandom_range(1, 4);
                        bno[k] = 0;
                    end
                    bno[k]++;
                    cur_data[k] = fixd ? 8'(8'h11 * bno[k]) : 8'($urandom);
                    cur_id[k]   = 8'($urandom);
                    cur_user[k] = 8'($urandom);
                    cur_last[k] = (rem[k] == 1);
                    v[k] = 1'b1;
                end else begin
                    v[k] = 1'b0;
                end
            end
        end
        m_ready = ($urandom_range(99) < pr);
    endtask

    // One clock: check outputs against the model, then apply the spec rules for the next edge
    task automatic step();
        logic [N-1:0] exp_rdy, hs;
        int was_idle;
        @(negedge clk);
        exp_rdy = (idle == 0 && (!mv || m_ready)) ? (N'(1) << g) : '0;
        chk("s_ready", s_ready, exp_rdy);
        chk("m_valid", m_valid, mv);
        if (mv) chk("slot", {m_data, m_id, m_user, m_last, m_src}, slot);
        if (m_valid && m_ready) begin
            if (!out_in) starts.push_back(int'(m_src));
            outs.push_back(m_data);
            out_in = !m_last;
        end
        hs = s_valid & exp_rdy;
        was_idle = idle;
        if (was_idle == 0 && hs[g]) begin
            slot = {cur_data[g], cur_id[g], cur_user[g], cur_last[g], port_idx_t'(g)};
            mv = 1'b1;
            if (cur_last[g]) begin
                lastg = g;
                idle = 1;
            end
        end else if (m_ready) begin
            mv = 1'b0;
        end
        if (was_idle != 0 && |s_valid) begin
            g = rr(s_valid, lastg);
            idle = 0;
        end
        @(posedge clk);
        #1 advance(hs);
    endtask

    task automatic chk_starts(string tag, int exp[]);
        chk({tag, "_n"}, (starts.size() >= exp.size()) ? 1 : 0, 1);
        for (int i = 0; i < exp.size() && i < starts.size(); i++)
            chk(tag, starts[i], exp[i]);
    endtask

    initial begin
        clear_all();
        #1;
        // idle after reset
        do_reset();
        repeat (10) step();
        // single 3-beat packet on port 2
        do_reset();
        plen = 3; fixd = 1'b1; go[2] = 1'b1;
        step();
        go[2] = 1'b0;
        repeat (8) step();
        chk_starts("t2_src", '{2});
        chk("t2_nbeats", outs.size(), 3);
        for (int i = 0; i < 3 && i < outs.size(); i++) chk("t2_data", outs[i], 8'h11 * (i + 1));
        fixd = 1'b0;
        // all ports requesting from reset
        do_reset();
        plen = 2; go = '1;
        repeat (20) step();
        chk_starts("t3_order", '{0, 1, 2, 3, 0});
        // downstream stall mid-packet with a competing request
        do_reset();
        plen = 4; go[1] = 1'b1; go[3] = 1'b1;
        repeat (4) step();
        pr = 0;
        repeat (5) step();
        pr = 100;
        repeat (20) step();
        chk_starts("t4_order", '{1, 3});
        // granted port goes quiet mid-packet
        do_reset();
        plen = 4; go[0] = 1'b1; go[1] = 1'b1;
        repeat (4) step();
        gap[0] = 1'b1;
        repeat (4) step();
        gap[0] = 1'b0;
        repeat (20) step();
        chk_starts("t5_order", '{0, 1});
        // reset pulse mid-packet
        do_reset();
        plen = 4; go[0] = 1'b1;
        repeat (4) step();
        chk("t6_pre_mv", m_valid, 1);
        reset_n = 1'b0;
        #1 chk("t6_async_mv", m_valid, 0);
        clear_all();
        @(posedge clk);
        #1 reset_n = 1'b1;
        plen = 2; go[0] = 1'b1; go[1] = 1'b1;
        repeat (20) step();
        chk_starts("t6_order", '{0, 1});
        // randomized traffic and backpressure
        do_reset();
        plen = 0; pv = 60; pr = 70; go = '1;
        repeat (3000) step();
        go = '0; pr = 100;
        repeat (40) step();
        chk("rand_drained", mv, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
